// File: rtl/axi_isram.sv
// AXI4-Lite read-only instruction SRAM slave (AR/R channels), one outstanding read.
// Define ISRAM_RAND_DELAY_EN to add an LFSR-driven 0..7 cycle jitter on top of LATENCY.
module axi_isram #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1,
    parameter              INIT_FILE = "",
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slv_ar_valid_i,
    input  logic [31:0] slv_ar_addr_i,
    output logic        slv_ar_ready_o,
    output logic        slv_r_valid_o,
    output logic [31:0] slv_r_data_o,
    output logic [1:0]  slv_r_resp_o,
    input  logic        slv_r_ready_i
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        ar_ready_q, ar_ready_d;
    logic        r_valid_q, r_valid_d;
    logic [31:0] r_data_q, r_data_d;
    logic [1:0]  r_resp_q, r_resp_d;

    logic [31:0] mem [DEPTH];

    logic [4:0] lat;

`ifdef ISRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lat     = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
`else
    assign lat = 5'(LATENCY);
`endif

    // Decode the live address at handshake, the latched one afterwards
    logic [31:0] src_addr;
    logic [29:0] widx;
    logic        misalign;
    logic        oob;
    logic [1:0]  resp_w;
    logic [31:0] data_w;

    assign src_addr = (state_q == S_IDLE) ? slv_ar_addr_i : addr_q;
    assign widx     = src_addr[31:2] - ADDR_BASE[31:2];
    assign misalign = src_addr[1:0] != 2'b00;
    assign oob      = widx >= 30'(DEPTH);

    always_comb begin
        resp_w = 2'b00;
        data_w = 32'h0;
        if (misalign) begin
            resp_w = 2'b10;
        end else if (oob) begin
            resp_w = 2'b11;
        end else begin
            data_w = mem[widx[AW-1:0]];
        end
    end

    logic ar_hs;
    logic load_resp;

    assign ar_hs = slv_ar_valid_i && ar_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        load_resp  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    addr_d     = slv_ar_addr_i;
                    cnt_d      = lat;
                    ar_ready_d = 1'b0;
                    if (lat == 5'd0) begin
                        state_d   = S_RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d   = S_RESP;
                    load_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (slv_r_ready_i) begin
                    r_valid_d  = 1'b0;
                    r_data_d   = 32'h0;
                    ar_ready_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load_resp) begin
            r_valid_d = 1'b1;
            r_data_d  = data_w;
            r_resp_d  = resp_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            addr_q     <= 32'h0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= 32'h0;
            r_resp_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign slv_ar_ready_o = ar_ready_q;
    assign slv_r_valid_o  = r_valid_q;
    assign slv_r_data_o   = r_data_q;
    assign slv_r_resp_o   = r_resp_q;

endmodule

// File: tb/tb_axi_isram.sv
// Randomized bench for axi_isram: three lanes (LATENCY 0, 1, 5) each checked
// cycle by cycle against a transaction-level model of the slave.
module tb_axi_isram;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          NREADS = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] dir_tbl [8] = '{
        32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
        32'h8000_0002, 32'h8000_4000, 32'h7FFF_FFFC, 32'h8000_3FFC
    };

    function automatic logic [31:0] word_of(int i);
        if (i == 0) return 32'h0000_0413;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // {resp, data} a correct slave must return for byte address a
    function automatic logic [33:0] expect_rd(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00) return {2'b10, 32'h0};
        if ((off >> 2) >= 32'(DEPTH)) return {2'b11, 32'h0};
        return {2'b00, word_of(int'(off >> 2))};
    endfunction

`ifdef ISRAM_RAND_DELAY_EN
    function automatic logic [7:0] lfsr_next(logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction
`endif

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_lane
        localparam int LAT = (k == 0) ? 0 : (k == 1) ? 1 : 5;

        logic        rst;
        logic        ar_valid;
        logic [31:0] ar_addr;
        logic        ar_ready;
        logic        r_valid;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_ready;
        bit          fin = 1'b0;
        bit   [31:0] lat_seen = '0;

        axi_isram #(.LATENCY(LAT)) dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .slv_ar_valid_i (ar_valid),
            .slv_ar_addr_i  (ar_addr),
            .slv_ar_ready_o (ar_ready),
            .slv_r_valid_o  (r_valid),
            .slv_r_data_o   (r_data),
            .slv_r_resp_o   (r_resp),
            .slv_r_ready_i  (r_ready)
        );

        initial begin
            for (int i = 0; i < DEPTH; i++) dut.mem[i] = word_of(i);
        end

        // Model: a read is outstanding from its AR edge until its R edge;
        // data is visible from edge t_ar+lat onwards.
        initial begin : model_chk
            bit          armed;
            bit          busy;
            bit          vexp;
            int          n;
            int          t_ar;
            int          lat_now;
            logic [33:0] pend;
            logic [1:0]  last_resp;
`ifdef ISRAM_RAND_DELAY_EN
            logic [7:0]  lfsr;
            lfsr = 8'hA5;
`endif
            armed = 0; busy = 0; vexp = 0; n = 0; t_ar = 0; lat_now = 0;
            pend = '0; last_resp = 2'b00;
            forever begin
                @(posedge clk);
                n++;
                if (rst) begin
                    armed = 1; busy = 0; vexp = 0; last_resp = 2'b00;
`ifdef ISRAM_RAND_DELAY_EN
                    lfsr = 8'hA5;
`endif
                end else if (armed) begin
                    if (!busy) begin
                        if (ar_valid) begin
                            busy    = 1;
                            t_ar    = n;
                            lat_now = LAT;
`ifdef ISRAM_RAND_DELAY_EN
                            lat_now = LAT + int'(lfsr[2:0]);
`endif
                            pend    = expect_rd(ar_addr);
                        end
                    end else if (vexp && r_ready) begin
                        busy = 0;
                    end
`ifdef ISRAM_RAND_DELAY_EN
                    lfsr = lfsr_next(lfsr);
`endif
                end
                vexp = busy && (n >= t_ar + lat_now);
                if (vexp) last_resp = pend[33:32];
                #1;
                if (armed) begin
                    chk($sformatf("L%0d ar_ready", LAT), 64'(ar_ready), 64'(!busy));
                    chk($sformatf("L%0d r_valid", LAT), 64'(r_valid), 64'(vexp));
                    chk($sformatf("L%0d r_data", LAT), 64'(r_data),
                        vexp ? 64'(pend[31:0]) : 64'h0);
                    chk($sformatf("L%0d r_resp", LAT), 64'(r_resp), 64'(last_resp));
                end
            end
        end

        // Called on a negedge; returns on the negedge after the R handshake.
        task automatic do_read(input logic [31:0] a, input int hold,
                               input bit pin, input logic [33:0] pin_val);
            int w;
            ar_valid = 1'b1;
            ar_addr  = a;
            w = 0;
            while (!ar_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!ar_ready) begin
                chk($sformatf("L%0d ar_timeout", LAT), 64'(ar_ready), 64'd1);
                ar_valid = 1'b0;
                return;
            end
            @(negedge clk);
            ar_valid = 1'b0;
            ar_addr  = $urandom;
            w = 0;
            while (!r_valid && w < 40) begin
                r_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                w++;
            end
            if (!r_valid) begin
                chk($sformatf("L%0d r_timeout", LAT), 64'(r_valid), 64'd1);
                return;
            end
            lat_seen[w[4:0]] = 1'b1;
`ifdef ISRAM_RAND_DELAY_EN
            chk($sformatf("L%0d lat_range", LAT), 64'(w >= LAT && w <= LAT + 7), 64'd1);
`else
            chk($sformatf("L%0d latency", LAT), 64'(w), 64'(LAT));
`endif
            if (pin) chk($sformatf("L%0d pinned", LAT), 64'({r_resp, r_data}), 64'(pin_val));
            repeat (hold) begin
                r_ready = 1'b0;
                @(negedge clk);
            end
            r_ready = 1'b1;
            @(negedge clk);
            r_ready = 1'($urandom_range(0, 1));
        endtask

        initial begin : driver
            logic [31:0] a;
            int          hold;
            rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int t = 0; t < NREADS; t++) begin
                if (t < 8) a = dir_tbl[t];
                else if ($urandom_range(0, 9) < 8) a = BASE + 4 * $urandom_range(0, DEPTH - 1);
                else a = $urandom;
                hold = (t < 4) ? 0 : (t == 4) ? 5 : $urandom_range(0, 3);
                unique case (t)
                    0:       do_read(a, hold, 1, {2'b00, 32'h0000_0413});
                    4:       do_read(a, hold, 1, {2'b10, 32'h0});
                    5, 6:    do_read(a, hold, 1, {2'b11, 32'h0});
                    default: do_read(a, hold, 0, '0);
                endcase
                if (t == 8) begin
                    ar_valid = 1'b1;
                    ar_addr  = BASE + 32'h10;
                    @(negedge clk);
                    ar_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk($sformatf("L%0d rst_ar_ready", LAT), 64'(ar_ready), 64'd1);
                    chk($sformatf("L%0d rst_r_valid", LAT), 64'(r_valid), 64'd0);
                end
                if (t >= 4) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
`ifdef ISRAM_RAND_DELAY_EN
            chk($sformatf("L%0d distinct_lat", LAT), 64'($countones(lat_seen) >= 4), 64'd1);
`endif
            fin = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(g_lane[0].fin && g_lane[1].fin && g_lane[2].fin) && c < 60000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!(g_lane[0].fin && g_lane[1].fin && g_lane[2].fin)) begin
            fails++;
            $display("FAIL run_timeout got=%0d exp=done", c);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
